// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Requester index: 0 = core data port, 1 = loader/debug port
    typedef logic req_idx_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selector: on a tie the requester not served last wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output req_idx_t   winner
);

    // A tied-high 'last' turns this into fixed priority for requester 0.
    always_comb begin
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester single-port memory arbiter (IDLE -> ISSUE -> WAIT FSM).
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise req[0] always wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [1:0][ADDR_W-1:0] addr,
    input  logic [1:0][DATA_W-1:0] wdata,
    output logic [1:0]             gnt,
    output logic [1:0]             rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   mem_wr,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wr_data,
    input  logic [DATA_W-1:0]      mem_rd_data,
    output logic                   busy
);

    if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..4");
    end

    arb_state_t        state;
    req_idx_t          win;
    req_idx_t          pick_win;
    req_idx_t          last;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        cnt;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last <= 1'b1;
        else if (state == ISSUE)
            last <= win;
    end
`else
    assign last = 1'b1;
`endif

    arb_pick u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            win       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            rvalid <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        win       <= pick_win;
                        lat_we    <= we[pick_win];
                        lat_addr  <= addr[pick_win];
                        lat_wdata <= wdata[pick_win];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= 3'd1;
                    state <= lat_we ? IDLE : WAIT;
                end
                WAIT: begin
                    // Last WAIT cycle is where the memory's data is valid.
                    if (cnt == 3'(MEM_LAT)) begin
                        rdata       <= mem_rd_data;
                        rvalid[win] <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        gnt         = '0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (state == ISSUE) begin
            gnt         = {win, ~win};
            mem_wr      = lat_we;
            mem_rd      = ~lat_we;
            mem_addr    = lat_addr;
            mem_wr_data = lat_wdata;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MEM_LAT=2.
module tb_mem_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 9;
    localparam int LAT = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [1:0]         req = '0;
    logic [1:0]         we = '0;
    logic [1:0][AW-1:0] addr = '0;
    logic [1:0][DW-1:0] wdata = '0;
    logic [1:0]         gnt;
    logic [1:0]         rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_wr;
    logic               mem_rd;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wr_data;
    logic [DW-1:0]      mem_rd_data;
    logic               busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Memory model: fixed read contents, data valid two cycles after the issue cycle.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        case (a)
            9'h1FF:  return 32'h12345678;
            9'h020:  return 32'hCAFEF00D;
            9'h030:  return 32'h0BADCAFE;
            default: return {23'h0, a};
        endcase
    endfunction

    logic [DW-1:0] d1, d2;
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;
    always @(posedge clk) begin
        d1 <= mem_word(mem_addr);
        d2 <= d1;
        if (mem_wr) begin
            last_wa <= mem_addr;
            last_wd <= mem_wr_data;
        end
    end
    assign mem_rd_data = d2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({gnt, rvalid, mem_wr, mem_rd, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt=%b rvalid=%b wr=%b rd=%b busy=%b, want all 0",
                     gnt, rvalid, mem_wr, mem_rd, busy);
        end
        checks++;
        if ({rdata, mem_addr, mem_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h addr=%h wd=%h, want 0", rdata, mem_addr, mem_wr_data);
        end
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_write();
        req = 2'b01; we = 2'b01; addr[0] = 9'h010; wdata[0] = 32'hDEADBEEF;
        step();
        checks++;
        if (gnt !== 2'b01 || mem_wr !== 1'b1 || mem_rd !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL write_issue: got gnt=%b wr=%b rd=%b busy=%b, want 01 1 0 1", gnt, mem_wr, mem_rd, busy);
        end
        checks++;
        if (mem_addr !== 9'h010 || mem_wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_bus: got addr=%h wd=%h, want 010 deadbeef", mem_addr, mem_wr_data);
        end
        req = '0;
        step();
        checks++;
        if (busy !== 1'b0 || gnt !== 2'b00 || mem_wr !== 1'b0 || rvalid !== 2'b00) begin
            errors++;
            $display("FAIL write_done: got busy=%b gnt=%b wr=%b rvalid=%b, want 0 00 0 00", busy, gnt, mem_wr, rvalid);
        end
        checks++;
        if (last_wa !== 9'h010 || last_wd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_mem: got addr=%h data=%h, want 010 deadbeef", last_wa, last_wd);
        end
    endtask

    task automatic test_read();
        req = 2'b10; we = 2'b00; addr[1] = 9'h1FF;
        step();
        checks++;
        if (gnt !== 2'b10 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 9'h1FF) begin
            errors++;
            $display("FAIL read_issue: got gnt=%b rd=%b wr=%b addr=%h, want 10 1 0 1ff", gnt, mem_rd, mem_wr, mem_addr);
        end
        req = '0;
        for (int i = 0; i < LAT; i++) begin
            step();
            checks++;
            if (busy !== 1'b1 || rvalid !== 2'b00 || gnt !== 2'b00 || mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL read_wait%0d: got busy=%b rvalid=%b gnt=%b rd=%b, want 1 00 00 0",
                         i, busy, rvalid, gnt, mem_rd);
            end
        end
        step();
        checks++;
        if (rvalid !== 2'b10 || rdata !== 32'h12345678 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_rvalid: got rvalid=%b rdata=%h busy=%b, want 10 12345678 0", rvalid, rdata, busy);
        end
        step();
        checks++;
        if (rvalid !== 2'b00 || rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL read_hold: got rvalid=%b rdata=%h, want 00 12345678", rvalid, rdata);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0]    exp_gnt;
        logic [AW-1:0] exp_addr;
        do_reset();
        req = 2'b11; we = 2'b11; addr[0] = 9'h0A0; addr[1] = 9'h0B1;
        wdata[0] = 32'h11111111; wdata[1] = 32'h22222222;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_gnt = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_gnt = 2'b01;
`endif
            exp_addr = (exp_gnt == 2'b01) ? 9'h0A0 : 9'h0B1;
            step();
            checks++;
            if (gnt !== exp_gnt || mem_addr !== exp_addr || mem_wr !== 1'b1) begin
                errors++;
                $display("FAIL simul_gnt%0d: got gnt=%b addr=%h wr=%b, want %b %h 1",
                         k, gnt, mem_addr, mem_wr, exp_gnt, exp_addr);
            end
            step();
            checks++;
            if (gnt !== 2'b00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL simul_idle%0d: got gnt=%b busy=%b, want 00 0", k, gnt, busy);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_reset_in_wait();
        req = 2'b01; we = 2'b00; addr[0] = 9'h020;
        step();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL rstwait_gnt: got %b want 01", gnt);
        end
        req = '0;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({gnt, rvalid, mem_wr, mem_rd, busy} !== 7'b0 || {rdata, mem_addr, mem_wr_data} !== '0) begin
            errors++;
            $display("FAIL rstwait_outs: got gnt=%b rvalid=%b busy=%b rdata=%h addr=%h, want all 0",
                     gnt, rvalid, busy, rdata, mem_addr);
        end
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rvalid !== 2'b00 || gnt !== 2'b00) begin
                errors++;
                $display("FAIL rstwait_quiet%0d: got rvalid=%b gnt=%b, want 00 00", i, rvalid, gnt);
            end
        end
        req = 2'b01; we = 2'b00; addr[0] = 9'h020;
        step();
        checks++;
        if (gnt !== 2'b01 || mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_regnt: got gnt=%b rd=%b, want 01 1", gnt, mem_rd);
        end
        req = '0;
        step();
        step();
        step();
        checks++;
        if (rvalid !== 2'b01 || rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rstwait_read: got rvalid=%b rdata=%h, want 01 cafef00d", rvalid, rdata);
        end
    endtask

    task automatic test_back_to_back();
        step();
        req = 2'b01; we = 2'b00; addr[0] = 9'h030;
        step();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gnt0: got %b want 01", gnt);
        end
        req = '0;
        step();
        step();
        step();
        checks++;
        if (rvalid !== 2'b01 || rdata !== 32'h0BADCAFE || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rvalid0: got rvalid=%b rdata=%h busy=%b, want 01 0badcafe 0", rvalid, rdata, busy);
        end
        req = 2'b10; we = 2'b00; addr[1] = 9'h1FF;
        step();
        checks++;
        if (gnt !== 2'b10 || mem_rd !== 1'b1 || mem_addr !== 9'h1FF) begin
            errors++;
            $display("FAIL b2b_gnt1: got gnt=%b rd=%b addr=%h, want 10 1 1ff", gnt, mem_rd, mem_addr);
        end
        req = '0;
        step();
        step();
        step();
        checks++;
        if (rvalid !== 2'b10 || rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_rvalid1: got rvalid=%b rdata=%h, want 10 12345678", rvalid, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_simultaneous();
        test_reset_in_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
